kronos_wb: RTL and testbench
============================

# kronos_wb

Kronos RISC-V 32I write-back stage: the consumer end of the EX/WB pipe. It accepts `pipeEXWB_t` packets under a valid/ready handshake and retires each one in one of four ways:
- writes the result to the register file;
- redirects the fetch on a taken branch;
- performs a load or store on the data bus;
- raises a trap.

It is the last stage of the Kronos core pipeline.

## Interface
Parameters: none.
- `clk`  in  1  core clock; one clock domain.
- `rstz`  in  1  reset, asynchronous, active-low.
- `execute`  in  pipeEXWB_t  EX/WB packet:
  - `result1`: ALU result, or load/store address;
  - `result2`: branch target, or store data;
  - `rd`, `rd_write`, `branch`, `branch_cond`, `ld`, `st`, `data_size`[1:0], `data_uns`, `is_illegal`.
- `pipe_in_vld`  in  1  packet valid.
- `pipe_in_rdy`  out  1  stage can accept.
- `regwr_data`  out  32  register-file write data.
- `regwr_sel`  out  5  register-file write index.
- `regwr_en`  out  1  register-file write strobe (1-cycle pulse).
- `branch_target`  out  32  fetch redirect address.
- `branch`  out  1  redirect pulse; also used upstream as pipeline flush.
- `data_addr`  out  32  word-aligned bus address.
- `data_req`  out  1  bus request, held until acknowledged.
- `data_wr_en`  out  1  1 = store, 0 = load.
- `data_mask`  out  4  byte enables.
- `data_wr_data`  out  32  store data, lane-aligned.
- `data_rd_data`  in  32  load data; valid in the cycle `data_ack` is high.
- `data_ack`  in  1  bus completion.
- `trap`  out  1  exception pulse.
- `trap_cause`  out  2  0 = illegal, 1 = misaligned load, 2 = misaligned store.

## Operation
States:
- **STEADY**: `pipe_in_rdy`=1. The packet is accepted on `pipe_in_vld`. Priority on accept:
  1. `is_illegal`: trap with cause 0; no write, branch, or bus activity.
  2. `ld` or `st`: go to **LSU**.
  3. Otherwise: ALU/jump retirement.
- **LSU**: `pipe_in_rdy`=0. `data_req` is held until `data_ack`, then return to STEADY.

ALU/jump retirement:
- `regwr_en` = `rd_write && rd != 0`, with `regwr_data` = `result1`.
- `branch` fires when `branch` is set, or when `branch_cond && result1[0]`. `branch_target` = `result2`.
- A jump (JAL/JALR) both writes its link value `result1` and branches.

Load/store addressing:
- `data_addr` = {`result1`[31:2], 2'b00}. Byte offset `off` = `result1`[1:0].
- `data_mask` by `data_size` (shifted left by `off`): 0 → 4'b0001, 1 → 4'b0011, 2 → 4'b1111.
- Store data: `data_wr_data` = `result2` byte/half replicated across lanes.

Load return:
- The selected lane is extracted using `off`.
- It is sign-extended, or zero-extended when `data_uns`=1.
- It is written to `rd` if `rd_write && rd != 0`.

Size encoding 3 is treated as word.

## Timing
Reset values: all outputs 0, state STEADY. `pipe_in_rdy` is 1 in the first cycle after reset release.

ALU ops:
- Packet accepted at cycle T.
- `regwr_en`/`branch`/`trap` pulse high in T+1 for exactly one cycle.
- Throughput is one packet per cycle.

Load/store:
- Accepted at T. `data_req`, `data_addr`, `data_mask`, `data_wr_en`, `data_wr_data` are registered and valid from T+1.
- These outputs are stable until the `data_ack` cycle A.
- `data_req` deasserts at A+1. Load `regwr_en` pulses in A+1.
- `pipe_in_rdy` rises in A+1, so the next accept is at A+1 at the earliest.
- `data_ack` in T+1 gives minimum latency: 2 cycles for a store, result written in T+2 for a load.

Handshake and boundary rules:
- `data_ack` outside LSU is ignored.
- Upstream must hold `execute` stable while `vld && !rdy`.
- Back-to-back: a branch pulse in T+1 coexists with a new accept in T+1. Discarding that packet is EX's duty via `flush`; WB does not filter it.
- Reset mid-LSU aborts immediately: `data_req` drops asynchronously and no write-back occurs.

## Configuration
`KRONOS_WB_MISALIGN_TRAP_EN`:
- **Defined:**
  - A misaligned access is one where `data_size`=1 with `off`[0]=1, or `data_size`≥2 with `off`≠0.
  - It issues no bus request and stays in STEADY.
  - It pulses `trap` in T+1 with cause 1 (load) or 2 (store).
  - It performs no register write.
- **Undefined:**
  - Offset bits beyond the access's natural alignment are ignored: half uses `off`[1] only, word uses `off`=0.
  - The aligned access is performed.
  - `trap_cause` values 1 and 2 never occur.

## Test plan
- ALU op `rd`=5, `rd_write`=1, `result1`=0x1234 → `regwr_en`=1, `regwr_sel`=5, `regwr_data`=0x1234 in T+1; 8 back-to-back ops retire in 8 cycles. Same op with `rd`=0 → no write.
- JAL: `branch`=1, `rd`=1, `result1`=0x104, `result2`=0x2000 → `branch`=1, `branch_target`=0x2000, x1 ← 0x104 in the same cycle. `branch_cond`=1 with `result1`=0 → no branch.
- LB: `result1`=0x1003 (`off`=3), `data_uns`=0, `data_rd_data`=0x80FF_FFFF, ack after 3 cycles → `data_addr`=0x1000, `data_mask`=4'b1000, `regwr_data`=0xFFFF_FF80. `pipe_in_rdy`=0 until A+1. LBU of the same → 0x80.
- SH: `result1`=0x2002, `result2`=0xABCD1234 → `data_wr_en`=1, `data_mask`=4'b1100, `data_wr_data`=0x1234_1234, `data_req` held until ack, no `regwr_en`.
- `is_illegal`=1 with `ld`=1 → `trap`=1, `trap_cause`=0, `data_req` stays 0. With the macro defined: LW at 0x1002 → `trap_cause`=1, no bus request; with it undefined → bus read at 0x1000, mask 4'b1111.
- Assert `rstz`=0 while `data_req`=1 → `data_req` and all outputs 0 immediately; `pipe_in_rdy`=1 after release.

Source files
------------

// File: rtl/kronos_wb.sv
// Kronos RV32I write-back stage: retires EX/WB packets as register writes, branches, bus accesses or traps.
// Optional build macro KRONOS_WB_MISALIGN_TRAP_EN turns misaligned loads/stores into traps instead of aligned accesses.
package kronos_wb_pkg;
  typedef struct packed {
    logic [31:0] result1;
    logic [31:0] result2;
    logic [4:0]  rd;
    logic        rd_write;
    logic        branch;
    logic        branch_cond;
    logic        ld;
    logic        st;
    logic [1:0]  data_size;
    logic        data_uns;
    logic        is_illegal;
  } pipeEXWB_t;
endpackage

module kronos_wb
  import kronos_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rstz,
  input  pipeEXWB_t   execute,
  input  logic        pipe_in_vld,
  output logic        pipe_in_rdy,
  output logic [31:0] regwr_data,
  output logic [4:0]  regwr_sel,
  output logic        regwr_en,
  output logic [31:0] branch_target,
  output logic        branch,
  output logic [31:0] data_addr,
  output logic        data_req,
  output logic        data_wr_en,
  output logic [3:0]  data_mask,
  output logic [31:0] data_wr_data,
  input  logic [31:0] data_rd_data,
  input  logic        data_ack,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  typedef enum logic {STEADY = 1'b0, LSU = 1'b1} state_e;

  state_e      state_q;
  logic        rd_write_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;

  logic [1:0]  off_s;
  logic [1:0]  eff_off_s;
  logic        misalign_s;
  logic [3:0]  mask_s;
  logic [31:0] wdata_s;
  logic [31:0] ld_word_s;
  logic [31:0] ld_data_s;

  // Offset bits finer than the access's natural alignment are dropped before lane selection.
  always_comb begin
    off_s = execute.result1[1:0];
    case (execute.data_size)
      2'd0: begin
        eff_off_s = off_s;
        mask_s    = 4'b0001 << off_s;
        wdata_s   = {4{execute.result2[7:0]}};
      end
      2'd1: begin
        eff_off_s = {off_s[1], 1'b0};
        mask_s    = 4'b0011 << {off_s[1], 1'b0};
        wdata_s   = {2{execute.result2[15:0]}};
      end
      default: begin
        eff_off_s = 2'b00;
        mask_s    = 4'b1111;
        wdata_s   = execute.result2;
      end
    endcase
  end

`ifdef KRONOS_WB_MISALIGN_TRAP_EN
  assign misalign_s = ((execute.data_size == 2'd1) && off_s[0]) ||
                      (execute.data_size[1] && (off_s != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  always_comb begin
    ld_word_s = data_rd_data >> {off_q, 3'b000};
    case (size_q)
      2'd0:    ld_data_s = {{24{~uns_q & ld_word_s[7]}}, ld_word_s[7:0]};
      2'd1:    ld_data_s = {{16{~uns_q & ld_word_s[15]}}, ld_word_s[15:0]};
      default: ld_data_s = ld_word_s;
    endcase
  end

  // Retirement FSM; every output is a register, pulses clear themselves each cycle.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q       <= STEADY;
      pipe_in_rdy   <= 1'b0;
      regwr_data    <= 32'h0;
      regwr_sel     <= 5'd0;
      regwr_en      <= 1'b0;
      branch_target <= 32'h0;
      branch        <= 1'b0;
      data_addr     <= 32'h0;
      data_req      <= 1'b0;
      data_wr_en    <= 1'b0;
      data_mask     <= 4'b0000;
      data_wr_data  <= 32'h0;
      trap          <= 1'b0;
      trap_cause    <= 2'd0;
      rd_write_q    <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'd0;
      off_q         <= 2'd0;
    end else begin
      regwr_en <= 1'b0;
      branch   <= 1'b0;
      trap     <= 1'b0;
      case (state_q)
        STEADY: begin
          pipe_in_rdy <= 1'b1;
          if (pipe_in_rdy && pipe_in_vld) begin
            if (execute.is_illegal) begin
              trap       <= 1'b1;
              trap_cause <= 2'd0;
            end else if (execute.ld || execute.st) begin
              if (misalign_s) begin
                trap       <= 1'b1;
                trap_cause <= execute.ld ? 2'd1 : 2'd2;
              end else begin
                state_q      <= LSU;
                pipe_in_rdy  <= 1'b0;
                data_req     <= 1'b1;
                data_addr    <= {execute.result1[31:2], 2'b00};
                data_wr_en   <= ~execute.ld;
                data_mask    <= mask_s;
                data_wr_data <= wdata_s;
                regwr_sel    <= execute.rd;
                rd_write_q   <= execute.rd_write & (execute.rd != 5'd0);
                size_q       <= execute.data_size;
                uns_q        <= execute.data_uns;
                off_q        <= eff_off_s;
              end
            end else begin
              regwr_en      <= execute.rd_write & (execute.rd != 5'd0);
              regwr_sel     <= execute.rd;
              regwr_data    <= execute.result1;
              branch        <= execute.branch | (execute.branch_cond & execute.result1[0]);
              branch_target <= execute.result2;
            end
          end
        end
        LSU: begin
          if (data_ack) begin
            state_q     <= STEADY;
            pipe_in_rdy <= 1'b1;
            data_req    <= 1'b0;
            regwr_en    <= ~data_wr_en & rd_write_q;
            regwr_data  <= ld_data_s;
          end
        end
        default: begin
          state_q     <= STEADY;
          pipe_in_rdy <= 1'b1;
          data_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kronos_wb.sv
// Self-checking bench for kronos_wb: directed test-plan cases pinned to literals, then randomized
// traffic compared every cycle against a transaction-level model of the write-back rules.
module tb_kronos_wb;
  import kronos_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rstz;
  pipeEXWB_t   execute;
  logic        pipe_in_vld;
  logic        pipe_in_rdy;
  logic [31:0] regwr_data;
  logic [4:0]  regwr_sel;
  logic        regwr_en;
  logic [31:0] branch_target;
  logic        branch;
  logic [31:0] data_addr;
  logic        data_req;
  logic        data_wr_en;
  logic [3:0]  data_mask;
  logic [31:0] data_wr_data;
  logic [31:0] data_rd_data;
  logic        data_ack;
  logic        trap;
  logic [1:0]  trap_cause;

  kronos_wb dut (
    .clk(clk), .rstz(rstz), .execute(execute), .pipe_in_vld(pipe_in_vld), .pipe_in_rdy(pipe_in_rdy),
    .regwr_data(regwr_data), .regwr_sel(regwr_sel), .regwr_en(regwr_en),
    .branch_target(branch_target), .branch(branch),
    .data_addr(data_addr), .data_req(data_req), .data_wr_en(data_wr_en), .data_mask(data_mask),
    .data_wr_data(data_wr_data), .data_rd_data(data_rd_data), .data_ack(data_ack),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic        m_rdy, m_busy;
  pipeEXWB_t   m_pkt;
  logic        e_wen, e_br, e_trap, e_req, e_we;
  logic [4:0]  e_sel;
  logic [31:0] e_wdat, e_tgt, e_addr, e_sdat;
  logic [1:0]  e_cause;
  logic [3:0]  e_mask;

  function automatic int wbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
  endfunction

  function automatic int eoff(input pipeEXWB_t p);
    int o = int'(p.result1[1:0]);
    int w = wbytes(p.data_size);
`ifdef KRONOS_WB_MISALIGN_TRAP_EN
    return o;
`else
    return (o / w) * w;
`endif
  endfunction

  function automatic logic misaligned(input pipeEXWB_t p);
`ifdef KRONOS_WB_MISALIGN_TRAP_EN
    return (int'(p.result1[1:0]) % wbytes(p.data_size)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] lane_mask(input pipeEXWB_t p);
    logic [3:0] m = 4'b0000;
    for (int b = 0; b < 4; b++) m[b] = (b >= eoff(p)) && (b < eoff(p) + wbytes(p.data_size));
    return m;
  endfunction

  function automatic logic [31:0] store_data(input pipeEXWB_t p);
    logic [31:0] v;
    int w = wbytes(p.data_size);
    for (int b = 0; b < 4; b++) v[8*b +: 8] = p.result2[8*(b % w) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] load_value(input pipeEXWB_t p, input logic [31:0] d);
    logic [31:0] v = 32'h0;
    int w = wbytes(p.data_size);
    int o = eoff(p);
    for (int k = 0; k < w; k++) v[8*k +: 8] = d[8*(o+k) +: 8];
    if (!p.data_uns && w < 4 && v[8*w-1])
      for (int k = w; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic model_reset();
    m_rdy = 1'b0; m_busy = 1'b0; m_pkt = '0;
    e_wen = 1'b0; e_br = 1'b0; e_trap = 1'b0; e_req = 1'b0; e_we = 1'b0;
    e_sel = 5'd0; e_wdat = 32'h0; e_tgt = 32'h0; e_addr = 32'h0; e_sdat = 32'h0;
    e_cause = 2'd0; e_mask = 4'b0000;
  endtask

  task automatic model_step();
    pipeEXWB_t p;
    e_wen = 1'b0; e_br = 1'b0; e_trap = 1'b0;
    if (m_busy) begin
      if (data_ack) begin
        m_busy = 1'b0;
        e_req = 1'b0;
        if (m_pkt.ld && m_pkt.rd_write && m_pkt.rd != 5'd0) begin
          e_wen = 1'b1; e_sel = m_pkt.rd; e_wdat = load_value(m_pkt, data_rd_data);
        end
      end
    end else if (m_rdy && pipe_in_vld) begin
      p = execute;
      if (p.is_illegal) begin
        e_trap = 1'b1; e_cause = 2'd0;
      end else if (p.ld || p.st) begin
        if (misaligned(p)) begin
          e_trap = 1'b1; e_cause = p.ld ? 2'd1 : 2'd2;
        end else begin
          m_busy = 1'b1; m_pkt = p; e_req = 1'b1;
          e_addr = p.result1 & 32'hFFFF_FFFC;
          e_we = !p.ld; e_mask = lane_mask(p); e_sdat = store_data(p);
        end
      end else begin
        if (p.rd_write && p.rd != 5'd0) begin
          e_wen = 1'b1; e_sel = p.rd; e_wdat = p.result1;
        end
        if (p.branch || (p.branch_cond && p.result1[0])) begin
          e_br = 1'b1; e_tgt = p.result2;
        end
      end
    end
    m_rdy = !m_busy;
  endtask

  task automatic compare_all();
    chk("rdy", 32'(pipe_in_rdy), 32'(m_rdy));
    chk("regwr_en", 32'(regwr_en), 32'(e_wen));
    chk("branch", 32'(branch), 32'(e_br));
    chk("trap", 32'(trap), 32'(e_trap));
    chk("data_req", 32'(data_req), 32'(e_req));
    if (e_wen) begin
      chk("regwr_sel", 32'(regwr_sel), 32'(e_sel));
      chk("regwr_data", regwr_data, e_wdat);
    end
    if (e_br) chk("branch_target", branch_target, e_tgt);
    if (e_trap) chk("trap_cause", 32'(trap_cause), 32'(e_cause));
    if (e_req) begin
      chk("data_addr", data_addr, e_addr);
      chk("data_mask", 32'(data_mask), 32'(e_mask));
      chk("data_wr_en", 32'(data_wr_en), 32'(e_we));
      if (e_we) chk("data_wr_data", data_wr_data, e_sdat);
    end
  endtask

  // One clock: model and DUT step on the rising edge, compare just after, return at falling edge.
  task automatic tick();
    @(posedge clk);
    if (rstz) model_step(); else model_reset();
    #1;
    if (rstz) compare_all();
    @(negedge clk);
  endtask

  function automatic pipeEXWB_t mk(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] rd,
                                   input logic rdw, input logic br, input logic bc, input logic ld,
                                   input logic st, input logic [1:0] sz, input logic uns, input logic ill);
    pipeEXWB_t p;
    p.result1 = r1; p.result2 = r2; p.rd = rd; p.rd_write = rdw; p.branch = br; p.branch_cond = bc;
    p.ld = ld; p.st = st; p.data_size = sz; p.data_uns = uns; p.is_illegal = ill;
    return p;
  endfunction

  function automatic pipeEXWB_t rand_pkt();
    pipeEXWB_t p = '0;
    int k = int'($urandom_range(0, 99));
    p.result1 = $urandom; p.result2 = $urandom;
    p.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    p.rd_write = ($urandom_range(0, 3) != 0);
    p.data_size = 2'($urandom);
    p.data_uns = 1'($urandom);
    if (k < 8) begin
      p.is_illegal = 1'b1; p.ld = 1'($urandom); p.st = 1'($urandom);
    end else if (k < 38) p.ld = 1'b1;
    else if (k < 55) p.st = 1'b1;
    else if (k < 70) p.branch_cond = 1'b1;
    else if (k < 78) p.branch = 1'b1;
    return p;
  endfunction

  logic acc, last_rdy;

  initial begin
    rstz = 1'b0; pipe_in_vld = 1'b0; execute = '0; data_ack = 1'b0; data_rd_data = 32'h0;
    model_reset();
    tick(); tick();
    chk("reset_rdy", 32'(pipe_in_rdy), 32'd0);
    chk("reset_req", 32'(data_req), 32'd0);
    chk("reset_wen", 32'(regwr_en), 32'd0);
    chk("reset_trap", 32'(trap), 32'd0);
    rstz = 1'b1;
    tick();
    chk("rdy_after_reset", 32'(pipe_in_rdy), 32'd1);

    // ALU write and 8 back-to-back retirements
    execute = mk(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    pipe_in_vld = 1'b1;
    tick();
    chk("alu_wen", 32'(regwr_en), 32'd1);
    chk("alu_sel", 32'(regwr_sel), 32'd5);
    chk("alu_data", regwr_data, 32'h1234);
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk("b2b_wen", 32'(regwr_en), 32'd1);
        chk("b2b_data", regwr_data, 32'h11 * (i - 1));
      end
      if (i < 8) execute = mk(32'h11 * i, 32'h0, 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      else pipe_in_vld = 1'b0;
      if (i < 8) tick();
    end
    execute = mk(32'h1234, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    pipe_in_vld = 1'b1;
    tick();
    chk("rd0_nowrite", 32'(regwr_en), 32'd0);

    // JAL, then a not-taken conditional branch
    execute = mk(32'h104, 32'h2000, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    chk("jal_branch", 32'(branch), 32'd1);
    chk("jal_target", branch_target, 32'h2000);
    chk("jal_link", regwr_data, 32'h104);
    chk("jal_wen", 32'(regwr_en), 32'd1);
    execute = mk(32'h0, 32'h3000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    chk("bcond_not_taken", 32'(branch), 32'd0);

    // LB then LBU at offset 3, ack three cycles after the request appears
    for (int u = 0; u < 2; u++) begin
      execute = mk(32'h1003, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'(u), 1'b0);
      pipe_in_vld = 1'b1;
      tick();
      pipe_in_vld = 1'b0;
      chk("lb_addr", data_addr, 32'h1000);
      chk("lb_mask", 32'(data_mask), 32'h8);
      chk("lb_rdy_low", 32'(pipe_in_rdy), 32'd0);
      tick();
      tick();
      chk("lb_req_held", 32'(data_req), 32'd1);
      data_ack = 1'b1; data_rd_data = 32'h80FF_FFFF;
      tick();
      data_ack = 1'b0;
      chk("lb_wen", 32'(regwr_en), 32'd1);
      chk("lb_data", regwr_data, (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      chk("lb_rdy_back", 32'(pipe_in_rdy), 32'd1);
    end

    // SH with minimum-latency ack
    execute = mk(32'h2002, 32'hABCD_1234, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    pipe_in_vld = 1'b1;
    tick();
    pipe_in_vld = 1'b0;
    chk("sh_we", 32'(data_wr_en), 32'd1);
    chk("sh_mask", 32'(data_mask), 32'hC);
    chk("sh_wdata", data_wr_data, 32'h1234_1234);
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    chk("sh_req_drop", 32'(data_req), 32'd0);
    chk("sh_nowrite", 32'(regwr_en), 32'd0);

    // Illegal load traps with cause 0
    execute = mk(32'h1000, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    pipe_in_vld = 1'b1;
    tick();
    chk("ill_trap", 32'(trap), 32'd1);
    chk("ill_cause", 32'(trap_cause), 32'd0);
    chk("ill_noreq", 32'(data_req), 32'd0);

    // LW at 0x1002
    execute = mk(32'h1002, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    tick();
    pipe_in_vld = 1'b0;
`ifdef KRONOS_WB_MISALIGN_TRAP_EN
    chk("lw_mis_trap", 32'(trap), 32'd1);
    chk("lw_mis_cause", 32'(trap_cause), 32'd1);
    chk("lw_mis_noreq", 32'(data_req), 32'd0);
`else
    chk("lw_mis_req", 32'(data_req), 32'd1);
    chk("lw_mis_addr", data_addr, 32'h1000);
    chk("lw_mis_mask", 32'(data_mask), 32'hF);
    data_ack = 1'b1; data_rd_data = 32'hCAFE_F00D;
    tick();
    data_ack = 1'b0;
    chk("lw_data", regwr_data, 32'hCAFE_F00D);
`endif

    // Reset while a load is outstanding
    execute = mk(32'h4000, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    pipe_in_vld = 1'b1;
    tick();
    pipe_in_vld = 1'b0;
    chk("rst_lsu_req", 32'(data_req), 32'd1);
    #2 rstz = 1'b0;
    model_reset();
    #1;
    chk("rst_async_req", 32'(data_req), 32'd0);
    chk("rst_async_rdy", 32'(pipe_in_rdy), 32'd0);
    chk("rst_async_wen", 32'(regwr_en), 32'd0);
    tick();
    rstz = 1'b1;
    tick();
    chk("rst_rdy_after", 32'(pipe_in_rdy), 32'd1);

    // Randomized traffic with random acks (including acks outside LSU)
    last_rdy = pipe_in_rdy;
    for (int n = 0; n < 4000; n++) begin
      acc = pipe_in_vld && last_rdy;
      last_rdy = pipe_in_rdy;
      if (acc || !pipe_in_vld) begin
        pipe_in_vld = ($urandom_range(0, 4) != 0);
        execute = rand_pkt();
      end
      data_ack = ($urandom_range(0, 2) == 0);
      data_rd_data = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
